// File: rtl/led7_disp_arbiter.sv
// Two-requester display arbiter: round-robin grant, saturating capture,
// sequential shift-add-3 binary-to-BCD conversion, then a minimum hold
// period before the next grant. All outputs are registered.
module led7_disp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        req_a,
  input  logic [13:0] val_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [13:0] val_b,
  output logic        ack_b,
  output logic [15:0] disp_bcd,
  output logic        disp_src,
  output logic        disp_update,
  output logic        disp_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);
  localparam logic [3:0]  ITER_LAST = 4'd14;
  localparam logic [13:0] BCD_MAX   = 14'd9999;

  state_t      state, state_nx;
  logic [3:0]  iter_cnt, iter_nx;
  logic [25:0] hold_cnt, hold_nx;
  logic [13:0] bin, bin_nx;
  logic [15:0] bcd, bcd_nx;
  logic        src, src_nx;
  logic        ovf, ovf_nx;
  logic        prio_b, prio_nx;

  logic        ack_a_nx, ack_b_nx;
  logic [15:0] disp_bcd_nx;
  logic        disp_src_nx, disp_ovf_nx, disp_update_nx, busy_nx;

  logic [15:0] bcd_adj;
  logic        sel_b;
  logic [13:0] sel_val;

  // Add-3 correction of every BCD nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Winner selection: a lone requester wins; on a tie the pointer decides
  always_comb begin
    sel_b   = req_b & (~req_a | prio_b);
    sel_val = sel_b ? val_b : val_a;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx       = state;
    iter_nx        = iter_cnt;
    hold_nx        = hold_cnt;
    bin_nx         = bin;
    bcd_nx         = bcd;
    src_nx         = src;
    ovf_nx         = ovf;
    prio_nx        = prio_b;
    ack_a_nx       = 1'b0;
    ack_b_nx       = 1'b0;
    disp_bcd_nx    = disp_bcd;
    disp_src_nx    = disp_src;
    disp_ovf_nx    = disp_ovf;
    disp_update_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_a || req_b) begin
          if (sel_val > BCD_MAX) begin
            bin_nx = BCD_MAX;
            ovf_nx = 1'b1;
          end else begin
            bin_nx = sel_val;
            ovf_nx = 1'b0;
          end
          src_nx   = sel_b;
          prio_nx  = ~sel_b;
          ack_a_nx = ~sel_b;
          ack_b_nx = sel_b;
          iter_nx  = '0;
          bcd_nx   = '0;
          state_nx = CONVERT;
        end
      end
      CONVERT: begin
        // Iterations run while the counter is 0..13; the edge that sees 14
        // publishes the result, giving a 15-clock ack-to-update latency.
        if (iter_cnt == ITER_LAST) begin
          disp_bcd_nx    = bcd;
          disp_src_nx    = src;
          disp_ovf_nx    = ovf;
          disp_update_nx = 1'b1;
          hold_nx        = '0;
          state_nx       = HOLD;
        end else begin
          bcd_nx  = {bcd_adj[14:0], bin[13]};
          bin_nx  = {bin[12:0], 1'b0};
          iter_nx = iter_cnt + 4'd1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = IDLE;
        end else begin
          hold_nx = hold_cnt + 26'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock_50Mhz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      hold_cnt    <= '0;
      bin         <= '0;
      bcd         <= '0;
      src         <= 1'b0;
      ovf         <= 1'b0;
      prio_b      <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      disp_bcd    <= '0;
      disp_src    <= 1'b0;
      disp_ovf    <= 1'b0;
      disp_update <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      iter_cnt    <= iter_nx;
      hold_cnt    <= hold_nx;
      bin         <= bin_nx;
      bcd         <= bcd_nx;
      src         <= src_nx;
      ovf         <= ovf_nx;
      prio_b      <= prio_nx;
      ack_a       <= ack_a_nx;
      ack_b       <= ack_b_nx;
      disp_bcd    <= disp_bcd_nx;
      disp_src    <= disp_src_nx;
      disp_ovf    <= disp_ovf_nx;
      disp_update <= disp_update_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_led7_disp_arbiter.sv
// Directed bench for led7_disp_arbiter with HOLD_CYCLES=4.
module tb_led7_disp_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, req_b;
  logic [13:0] val_a, val_b;
  logic        ack_a, ack_b;
  logic [15:0] disp_bcd;
  logic        disp_src, disp_update, disp_ovf, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led7_disp_arbiter #(.HOLD_CYCLES(4)) dut (
    .clock_50Mhz (clk),
    .reset       (reset),
    .req_a       (req_a),
    .val_a       (val_a),
    .ack_a       (ack_a),
    .req_b       (req_b),
    .val_b       (val_b),
    .ack_b       (ack_b),
    .disp_bcd    (disp_bcd),
    .disp_src    (disp_src),
    .disp_update (disp_update),
    .disp_ovf    (disp_ovf),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle stamp used for grant spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Both acks together is never legal
  always @(negedge clk) begin
    if (reset && ack_a && ack_b) begin
      errors++;
      $display("FAIL ack_exclusive: ack_a=%0b ack_b=%0b required not both", ack_a, ack_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  // Waits (bounded) for an ack, then for disp_update; reports what it saw
  task automatic observe_grant(output int ack_cyc, output logic got_a, output logic got_b,
                               output int upd_lat, output logic [15:0] bcd,
                               output logic src, output logic ovf);
    int n;
    ack_cyc = -1; got_a = 1'b0; got_b = 1'b0; upd_lat = -1;
    bcd = '0; src = 1'b0; ovf = 1'b0;
    n = 0;
    while (n < 60 && !(ack_a || ack_b)) begin
      tick();
      n++;
    end
    if (ack_a || ack_b) begin
      ack_cyc = cyc;
      got_a   = ack_a;
      got_b   = ack_b;
      n = 0;
      while (n < 60 && !disp_update) begin
        tick();
        n++;
      end
      if (disp_update) begin
        upd_lat = n;
        bcd     = disp_bcd;
        src     = disp_src;
        ovf     = disp_ovf;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 100 && busy) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0; val_a = '0; val_b = '0;
    repeat (2) tick();
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL reset_ack_a: got %0b required 0", ack_a); end
    checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL reset_ack_b: got %0b required 0", ack_b); end
    checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h required 0000", disp_bcd); end
    checks++; if (disp_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %0b required 0", disp_src); end
    checks++; if (disp_update !== 1'b0) begin errors++; $display("FAIL reset_update: got %0b required 0", disp_update); end
    checks++; if (disp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b required 0", disp_ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int ac, ul; logic ga, gb, s, o; logic [15:0] b;
    do_reset();
    val_a = 14'd1234;
    req_a = 1'b1;
    observe_grant(ac, ga, gb, ul, b, s, o);
    req_a = 1'b0;
    checks++; if (ga !== 1'b1 || gb !== 1'b0) begin errors++; $display("FAIL basic_ack: a=%0b b=%0b required a=1 b=0", ga, gb); end
    checks++; if (ul != 15) begin errors++; $display("FAIL basic_latency: got %0d required 15", ul); end
    checks++; if (b !== 16'h1234) begin errors++; $display("FAIL basic_bcd: got %h required 1234", b); end
    checks++; if (s !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL basic_src_ovf: src=%0b ovf=%0b required 0 0", s, o); end
    tick();
    checks++; if (disp_update !== 1'b0) begin errors++; $display("FAIL basic_update_pulse: got %0b required 0", disp_update); end
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL basic_ack_pulse: got %0b required 0", ack_a); end
    repeat (2) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %0b required 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b required 0", busy); end
    repeat (3) tick();
    checks++; if (disp_bcd !== 16'h1234) begin errors++; $display("FAIL basic_idle_keep: got %h required 1234", disp_bcd); end
  endtask

  task automatic test_round_robin();
    int ac, ul, prev; logic ga, gb, s, o; logic [15:0] b;
    logic        exp_a;
    logic [15:0] exp_bcd;
    do_reset();
    val_a = 14'd5;
    val_b = 14'd9876;
    req_a = 1'b1;
    req_b = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      exp_a   = (k % 2 == 0);
      exp_bcd = exp_a ? 16'h0005 : 16'h9876;
      observe_grant(ac, ga, gb, ul, b, s, o);
      checks++; if (ga !== exp_a || gb !== !exp_a) begin errors++; $display("FAIL rr_order_%0d: a=%0b b=%0b required a=%0b", k, ga, gb, exp_a); end
      checks++; if (b !== exp_bcd || s !== !exp_a) begin errors++; $display("FAIL rr_value_%0d: bcd=%h src=%0b required %h %0b", k, b, s, exp_bcd, !exp_a); end
      if (k > 0) begin
        checks++; if (ac - prev != 20) begin errors++; $display("FAIL rr_spacing_%0d: got %0d required 20", k, ac - prev); end
      end
      prev = ac;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    wait_idle("rr");
  endtask

  task automatic test_saturation();
    int          ac, ul; logic ga, gb, s, o; logic [15:0] b;
    int          vals[3]  = '{16383, 10000, 9999};
    logic        use_b[3] = '{1'b1, 1'b0, 1'b1};
    logic        exp_o[3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      val_a = 14'(vals[i]);
      val_b = 14'(vals[i]);
      req_a = !use_b[i];
      req_b = use_b[i];
      observe_grant(ac, ga, gb, ul, b, s, o);
      req_a = 1'b0;
      req_b = 1'b0;
      checks++; if (b !== 16'h9999) begin errors++; $display("FAIL sat_bcd_%0d: got %h required 9999", i, b); end
      checks++; if (o !== exp_o[i]) begin errors++; $display("FAIL sat_ovf_%0d: got %0b required %0b", i, o, exp_o[i]); end
      checks++; if (s !== use_b[i]) begin errors++; $display("FAIL sat_src_%0d: got %0b required %0b", i, s, use_b[i]); end
      wait_idle("sat");
    end
  endtask

  task automatic test_digit_boundaries();
    int          ac, ul; logic ga, gb, s, o; logic [15:0] b;
    int          vals[5] = '{0, 9999, 1000, 59, 8080};
    logic [15:0] expv[5] = '{16'h0000, 16'h9999, 16'h1000, 16'h0059, 16'h8080};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      val_a = 14'(vals[i]);
      req_a = 1'b1;
      observe_grant(ac, ga, gb, ul, b, s, o);
      req_a = 1'b0;
      checks++; if (ul != 15 || b !== expv[i] || o !== 1'b0) begin
        errors++;
        $display("FAIL digits_%0d: lat=%0d bcd=%h ovf=%0b required 15 %h 0", i, ul, b, o, expv[i]);
      end
      wait_idle("digits");
    end
  endtask

  task automatic test_reset_abort();
    int upd, acks;
    do_reset();
    val_a = 14'd4321;
    req_a = 1'b1;
    tick();
    checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL abort_ack: got %0b required 1", ack_a); end
    repeat (7) tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      errors++; $display("FAIL abort_async: busy=%0b ack_a=%0b ack_b=%0b required 0 0 0", busy, ack_a, ack_b);
    end
    checks++; if (disp_bcd !== 16'h0000 || disp_update !== 1'b0 || disp_ovf !== 1'b0 || disp_src !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: bcd=%h upd=%0b ovf=%0b src=%0b required 0000 0 0 0", disp_bcd, disp_update, disp_ovf, disp_src);
    end
    req_a = 1'b0;
    tick();
    reset = 1'b1;
    upd = 0; acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (disp_update) upd++;
      if (ack_a || ack_b) acks++;
    end
    checks++; if (upd != 0 || acks != 0) begin errors++; $display("FAIL abort_silent: updates=%0d acks=%0d required 0 0", upd, acks); end
    checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL abort_bcd: got %h required 0000", disp_bcd); end
  endtask

  task automatic test_hold_pending();
    int ac, ul, n, acks; logic ga, gb, s, o; logic [15:0] b;
    do_reset();
    val_a = 14'd42;
    req_a = 1'b1;
    observe_grant(ac, ga, gb, ul, b, s, o);
    req_a = 1'b0;
    val_b = 14'd77;
    req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL pend_early_%0d: ack_b=%0b required 0", i, ack_b); end
    end
    tick();
    checks++; if (ack_b !== 1'b1) begin errors++; $display("FAIL pend_grant: ack_b=%0b required 1", ack_b); end
    req_b = 1'b0;
    n = 0;
    while (n < 40 && !disp_update) begin
      tick();
      n++;
    end
    checks++; if (disp_update !== 1'b1 || disp_bcd !== 16'h0077 || disp_src !== 1'b1) begin
      errors++; $display("FAIL pend_value: upd=%0b bcd=%h src=%0b required 1 0077 1", disp_update, disp_bcd, disp_src);
    end
    wait_idle("pend");
    val_a = 14'd5;
    req_a = 1'b1;
    observe_grant(ac, ga, gb, ul, b, s, o);
    req_a = 1'b0;
    req_b = 1'b1;
    repeat (2) tick();
    req_b = 1'b0;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ack_b) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL pend_withdrawn: ack_b pulses=%0d required 0", acks); end
    checks++; if (disp_bcd !== 16'h0005 || disp_src !== 1'b0) begin errors++; $display("FAIL pend_keep: bcd=%h src=%0b required 0005 0", disp_bcd, disp_src); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_saturation();
    test_digit_boundaries();
    test_reset_abort();
    test_hold_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
